plot_fb_writer: RTL and testbench

//  Downstream of the triangle rasteriser. Captures its per-cycle plot strobes (x, y, plot, colour), which carry no backpressure.

---
 rtl/plot_fb_writer_if.sv | 26 ++
 rtl/plot_fb_writer.sv | 137 +++++++++++++
 tb/tb_plot_fb_writer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/plot_fb_writer_if.sv
// Pixel bus between the rasteriser, the framebuffer writer and the memory arbiter.
//   vga_x/vga_y/vga_plot/colour : per-cycle plot strobe from the rasteriser (no backpressure)
//   fb_addr/fb_data/fb_we       : framebuffer write request toward the arbiter
//   fb_ready                    : arbiter accepts the write on an edge where fb_we && fb_ready
// The slave modport is the writer's view. The master modport is the surrounding
// environment's view: it drives the strobes and fb_ready.
interface plot_fb_writer_if;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic        vga_plot;
  logic [2:0]  colour;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;

  modport slave (
    input  vga_x, vga_y, vga_plot, colour, fb_ready,
    output fb_addr, fb_data, fb_we
  );

  modport master (
    output vga_x, vga_y, vga_plot, colour, fb_ready,
    input  fb_addr, fb_data, fb_we
  );
endinterface

// File: rtl/plot_fb_writer.sv
// Framebuffer writer downstream of the triangle rasteriser.
// Clips plot strobes to the visible screen, buffers accepted pixels in a FIFO,
// and issues linear-address framebuffer writes under a valid/ready handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : plot strobe inputs and framebuffer write outputs (slave modport)
//   clr_status  : synchronous clear of overflow and clip_count
//   idle        : FIFO empty and no pending write
//   overflow    : sticky, an in-screen pixel was dropped because the buffer was full
//   clip_count  : saturating count of off-screen pixels
module plot_fb_writer #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  plot_fb_writer_if.slave       bus,
  input  logic                  clr_status,
  output logic                  idle,
  output logic                  overflow,
  output logic [15:0]           clip_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Linear framebuffer address; operands widened before the multiply so the
  // full 15-bit product survives.
  function automatic logic [14:0] lin_addr(input logic [7:0] x, input logic [6:0] y);
    lin_addr = 15'(y) * 15'(SCREEN_W) + 15'(x);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // FIFO entry layout: {x[7:0], y[6:0], colour[2:0]}
  logic [17:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             we_q, we_d;
  logic [14:0]      addr_q, addr_d;
  logic [2:0]       data_q, data_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      clip_q, clip_d;

  logic        in_screen;
  logic        clip_evt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic        drop;
  logic [17:0] head;

  always_comb begin
    in_screen  = bus.vga_plot && (int'(bus.vga_x) < SCREEN_W) && (int'(bus.vga_y) < SCREEN_H);
    clip_evt   = bus.vga_plot && !in_screen;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(DEPTH));
    head       = mem_q[rd_ptr_q];

    // The output register takes a new entry when it is empty or its current
    // write is being accepted this edge, which gives back-to-back writes.
    pop  = !fifo_empty && (!we_q || bus.fb_ready);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = in_screen && (!fifo_full || pop);
    drop = in_screen && !push;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      we_d   = 1'b1;
      addr_d = lin_addr(head[17:10], head[9:3]);
      data_d = head[2:0];
    end else if (we_q && bus.fb_ready) begin
      we_d = 1'b0;
    end

    // A new event in the same cycle as a clear takes priority over the clear.
    overflow_d = overflow_q;
    if (drop)            overflow_d = 1'b1;
    else if (clr_status) overflow_d = 1'b0;

    clip_d = clip_q;
    if (clip_evt)        clip_d = clr_status ? 16'd1 : sat_inc(clip_q);
    else if (clr_status) clip_d = 16'd0;
  end

  // FIFO storage carries data only, so it is written without reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.vga_x, bus.vga_y, bus.colour};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      clip_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      clip_q     <= clip_d;
    end
  end

  assign bus.fb_we   = we_q;
  assign bus.fb_addr = addr_q;
  assign bus.fb_data = data_q;
  assign idle        = fifo_empty && !we_q;
  assign overflow    = overflow_q;
  assign clip_count  = clip_q;

endmodule

// File: tb/tb_plot_fb_writer.sv
module tb_plot_fb_writer;
  localparam int DEPTH = 8;
  localparam int SW    = 160;
  localparam int SH    = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_status = 1'b0;
  logic        idle;
  logic        overflow;
  logic [15:0] clip_count;

  plot_fb_writer_if bus();

  plot_fb_writer #(.DEPTH(DEPTH), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_status (clr_status),
    .idle       (idle),
    .overflow   (overflow),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: a queue of buffered pixels, each stored as its target
  // (address*8 + colour), plus one pending-write slot in front of it.
  int  m_q[$];
  bit  m_v;
  int  m_addr;
  int  m_data;
  bit  m_ovf;
  int  m_clip;
  int  n_wr;
  bit  chk_en = 1'b1;

  task automatic model_reset();
    m_q.delete();
    m_v    = 1'b0;
    m_addr = 0;
    m_data = 0;
    m_ovf  = 1'b0;
    m_clip = 0;
  endtask

  task automatic model_edge(input bit pl, input int x, input int y, input int c,
                            input bit rdy, input bit clr);
    bit ins, pop, push;
    int e;
    ins  = pl && (x < SW) && (y < SH);
    pop  = (m_q.size() > 0) && (!m_v || rdy);
    push = ins && ((m_q.size() < DEPTH) || pop);
    if (m_v && rdy) n_wr++;
    if (pop) begin
      e      = m_q.pop_front();
      m_addr = e / 8;
      m_data = e % 8;
      m_v    = 1'b1;
    end else if (rdy) begin
      m_v = 1'b0;
    end
    if (push) m_q.push_back((y * SW + x) * 8 + c);
    if (pl && !ins)  m_clip = clr ? 1 : ((m_clip < 65535) ? m_clip + 1 : 65535);
    else if (clr)    m_clip = 0;
    if (ins && !push) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
  endtask

  task automatic compare();
    chk("fb_we", 32'(bus.fb_we), 32'(m_v));
    if (m_v) begin
      chk("fb_addr", 32'(bus.fb_addr), 32'(m_addr));
      chk("fb_data", 32'(bus.fb_data), 32'(m_data));
    end
    chk("idle", 32'(idle), 32'((m_q.size() == 0) && !m_v));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("clip_count", 32'(clip_count), 32'(m_clip));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check.
  task automatic step(input bit pl, input int x, input int y, input int c,
                      input bit rdy, input bit clr);
    bus.vga_plot = pl;
    bus.vga_x    = 8'(x);
    bus.vga_y    = 7'(y);
    bus.colour   = 3'(c);
    bus.fb_ready = rdy;
    clr_status   = clr;
    @(posedge clk);
    model_edge(pl, x, y, c, rdy, clr);
    #1;
    if (chk_en) compare();
  endtask

  task automatic no_plot(input bit rdy, input bit clr);
    step(1'b0, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7), rdy, clr);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4; i++) no_plot(1'b1, 1'b0);
    chk("drain_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    bus.vga_plot = 1'b0;
    bus.vga_x    = '0;
    bus.vga_y    = '0;
    bus.colour   = '0;
    bus.fb_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(bus.fb_we), 32'd0);
    chk("rst_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_data", 32'(bus.fb_data), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_clip", 32'(clip_count), 32'd0);
    rst = 1'b0;

    // Single pixel latency and address
    step(1'b1, 3, 2, 5, 1'b1, 1'b0);
    chk("t1_we_n1", 32'(bus.fb_we), 32'd0);
    no_plot(1'b1, 1'b0);
    chk("t1_we_n2", 32'(bus.fb_we), 32'd1);
    chk("t1_addr", 32'(bus.fb_addr), 32'd323);
    chk("t1_data", 32'(bus.fb_data), 32'd5);
    no_plot(1'b1, 1'b0);
    chk("t1_idle", 32'(idle), 32'd1);

    // Clipping on each axis
    step(1'b1, 160, 0, 1, 1'b1, 1'b0);
    step(1'b1, 0, 120, 2, 1'b1, 1'b0);
    no_plot(1'b1, 1'b0);
    no_plot(1'b1, 1'b0);
    chk("t2_clip", 32'(clip_count), 32'd2);
    chk("t2_ovf", 32'(overflow), 32'd0);
    chk("t2_idle", 32'(idle), 32'd1);

    // Capacity with the arbiter stalled, then ordered drain
    n_wr = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 10 + i, 20 + i, i % 8, 1'b0, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 14; i++) no_plot(1'b1, 1'b0);
    chk("t3_writes", 32'(n_wr), 32'd9);

    // Full buffer with sustained flow: no drops
    no_plot(1'b0, 1'b1);
    chk("t4_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 100 + i, 50, i % 8, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 40 + i, 60 + i, (i + 3) % 8, 1'b1, 1'b0);
      chk("t4_we", 32'(bus.fb_we), 32'd1);
    end
    chk("t4_ovf", 32'(overflow), 32'd0);
    drain();

    // Reset in the middle of a stalled write
    for (int i = 0; i < 5; i++) step(1'b1, 7 * i, 3 * i, i, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_we", 32'(bus.fb_we), 32'd0);
    chk("t5_idle", 32'(idle), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 159, 119, 6, 1'b0, 1'b0);
    no_plot(1'b0, 1'b0);
    chk("t5_we2", 32'(bus.fb_we), 32'd1);
    chk("t5_addr", 32'(bus.fb_addr), 32'd19199);
    chk("t5_data", 32'(bus.fb_data), 32'd6);
    drain();

    // Clip counter saturation and clear priority
    no_plot(1'b1, 1'b1);
    chk_en = 1'b0;
    for (int i = 0; i < 65535; i++) step(1'b1, 200, 5, 0, 1'b1, 1'b0);
    chk_en = 1'b1;
    compare();
    chk("t6_full", 32'(clip_count), 32'hFFFF);
    step(1'b1, 170, 10, 0, 1'b1, 1'b0);
    chk("t6_sat", 32'(clip_count), 32'hFFFF);
    step(1'b1, 10, 125, 0, 1'b1, 1'b1);
    chk("t6_clr_win", 32'(clip_count), 32'd1);
    no_plot(1'b1, 1'b1);
    chk("t6_clr", 32'(clip_count), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 175), $urandom_range(0, 127),
           $urandom_range(0, 7), ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
